fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequencing controller for the fetch stage of the 5-stage RISC-V core. Drives the program counter's `en` / `jump_en` / `jump_addr` controls, the instruction-memory request, and the IF/ID and ID/EX enable/flush controls. Arbitrates between:
- boot,
- EX-stage branch/jump redirects,
- load-use stalls from the hazard unit,
- instruction-memory wait cycles,
- halt/resume requests.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, PC / target address width
- `RESET_VECTOR`, 32'h0000_0000, address loaded into the PC during boot
- `BOOT_DELAY`, 2, number of boot cycles after reset release; legal range 1..15
- `TRAP_VECTOR`, 32'h0000_0100, misaligned-target trap address (used only with `FETCH_MISALIGN_TRAP_EN`)

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high reset
- `branch_taken` in 1: EX stage resolved a taken branch or jump this cycle
- `branch_target` in ADDR_WIDTH: redirect target, valid when `branch_taken`=1
- `load_use_stall` in 1: hazard unit requests a stall of IF/ID
- `halt_req` in 1: pulse; enter HALT
- `resume` in 1: pulse; leave HALT
- `imem_ready` in 1: instruction memory returns a valid instruction this cycle
- `imem_req` out 1: fetch request at the current PC
- `pc_en` out 1: PC update enable
- `pc_jump_en` out 1: PC loads `pc_jump_addr` instead of PC+4
- `pc_jump_addr` out ADDR_WIDTH: PC load value
- `if_id_en` out 1: IF/ID register capture enable
- `if_id_flush` out 1: IF/ID loads a bubble (NOP, valid=0)
- `id_ex_flush` out 1: ID/EX loads a bubble
- `halted` out 1: high while in HALT
- `misalign_trap` out 1: one-cycle pulse (only with `FETCH_MISALIGN_TRAP_EN`; tied 0 otherwise)

## Operation
- FSM states: BOOT, RUN, HALT. The state register and the 4-bit boot counter are the only sequential state.
- All outputs are combinational from the state plus the current inputs, so a stall or redirect takes effect at the same clock edge.
- `reset`=1 at a rising edge sets state BOOT and loads the boot counter with `BOOT_DELAY`-1. This applies at any time, including mid-redirect or in HALT.

BOOT:
- Outputs: `pc_en`=1, `pc_jump_en`=1, `pc_jump_addr`=`RESET_VECTOR`, `if_id_flush`=1, `id_ex_flush`=1, `imem_req`=0, `if_id_en`=0.
- The counter decrements each cycle. When it reaches 0, the next state is RUN.
- All other inputs are ignored.

RUN, strict priority, first match wins:
1. `branch_taken`: `pc_en`=1, `pc_jump_en`=1, `pc_jump_addr`=`{branch_target[ADDR_WIDTH-1:2],2'b00}`, `if_id_flush`=1, `id_ex_flush`=1, `if_id_en`=0. Applies regardless of `imem_ready`, stall or halt; the halt is dropped.
2. `halt_req`: `pc_en`=0, `if_id_flush`=1; next state HALT.
3. `load_use_stall`: `pc_en`=0, `if_id_en`=0, `if_id_flush`=0, `id_ex_flush`=1.
4. `imem_ready`=0: `pc_en`=0, `if_id_en`=0, `if_id_flush`=1.
5. Otherwise: `pc_en`=1, `pc_jump_en`=0, `if_id_en`=1.

- `imem_req`=1 throughout RUN.
- Any output not named in a row is 0; `pc_jump_addr` is `RESET_VECTOR` when `pc_jump_en`=0.

HALT:
- Outputs: `imem_req`=0, `pc_en`=0, `if_id_en`=0, `if_id_flush`=1, `halted`=1.
- `branch_taken` still redirects the PC (row 1 outputs) and the state stays HALT, so in-flight jumps complete.
- `resume`: next state RUN. `resume` and `halt_req` both high in HALT: `resume` wins.

## Timing
- Reset values, from the edge where `reset`=1 until BOOT exits: state BOOT, `halted`=0, `misalign_trap`=0, `imem_req`=0, with the BOOT outputs above.
- First `imem_req`=1 occurs exactly `BOOT_DELAY` cycles after the first edge with `reset`=0.
- Redirect latency: `branch_taken` at edge N means the PC equals the target after edge N. The fetch at the target is issued in cycle N+1.
- There is no pending state: a redirect is never deferred, and a stall asserted together with a redirect is discarded.
- `halt_req` at edge N gives `halted`=1 from cycle N+1. `resume` at edge M gives `imem_req`=1 from cycle M+1, at the unchanged PC.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - In RUN or HALT, `branch_taken` with `branch_target[1:0]`≠0 loads `TRAP_VECTOR` instead of the target.
  - Pulses `misalign_trap` for that cycle.
  - Flushes are the same as a normal redirect.
- `FETCH_MISALIGN_TRAP_EN` undefined: `branch_target[1:0]` is silently forced to 00, and `misalign_trap` is tied 0.

## Test plan
- Reset/boot: `reset`=1 for 3 cycles, then 0, with `BOOT_DELAY`=2 → `pc_jump_addr`=0 and both flushes high for 2 cycles; `imem_req` rises on the 3rd cycle; PC goes 0, 4, 8 with `imem_ready`=1.
- Redirect vs stall: PC=8, `branch_taken`=1, `branch_target`=32'hCAFE_BABC, `load_use_stall`=1 in the same cycle → `pc_jump_en`=1, both flushes high; the next PC is CAFE_BABC, then CAFE_BAC0.
- Stall and wait: `load_use_stall` for 2 cycles → PC held, `if_id_en`=0, `id_ex_flush`=1. Then `imem_ready`=0 for 3 cycles → PC held, `if_id_flush`=1. Then `imem_ready`=1 → PC+4 per cycle.
- Halt/resume: `halt_req` pulse at PC=0x20 → `halted`=1 and `imem_req`=0 until `resume`; then the fetch resumes at 0x20. `branch_taken` to 0x40 while halted → PC=0x40, `halted` stays 1.
- Misaligned target 32'hCAFE_BABE: with `FETCH_MISALIGN_TRAP_EN` → PC=0x100 and a 1-cycle `misalign_trap`; without it → PC=CAFE_BABC.
- Reset during HALT and during a redirect cycle → BOOT the next cycle, `halted`=0, PC reloaded to `RESET_VECTOR`.

Source files
------------

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: boot, redirect, stall, imem-wait and halt arbitration for PC/IF/ID/ID/EX.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_controller #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int                    BOOT_DELAY   = 2,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  load_use_stall,
  input  logic                  halt_req,
  input  logic                  resume,
  input  logic                  imem_ready,
  output logic                  imem_req,
  output logic                  pc_en,
  output logic                  pc_jump_en,
  output logic [ADDR_WIDTH-1:0] pc_jump_addr,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  halted,
  output logic                  misalign_trap
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t                state, state_next;
  logic [3:0]            boot_cnt;
  logic                  misaligned;
  logic [ADDR_WIDTH-1:0] redirect_addr;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned    = (branch_target[1:0] != 2'b00);
  assign redirect_addr = misaligned ? TRAP_VECTOR : {branch_target[ADDR_WIDTH-1:2], 2'b00};
`else
  // Low target bits are dropped; the AND keeps them formally consumed.
  assign misaligned    = 1'b0;
  assign redirect_addr = {branch_target[ADDR_WIDTH-1:2], branch_target[1:0] & 2'b00};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      boot_cnt <= 4'(BOOT_DELAY - 1);
    end else begin
      state <= state_next;
      if (state == BOOT && boot_cnt != 4'd0) boot_cnt <= boot_cnt - 4'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    if (boot_cnt == 4'd0) state_next = RUN;
      RUN:     if (!branch_taken && halt_req) state_next = HALT;
      HALT:    if (resume) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    imem_req      = 1'b0;
    pc_en         = 1'b0;
    pc_jump_en    = 1'b0;
    pc_jump_addr  = RESET_VECTOR;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    halted        = 1'b0;
    misalign_trap = 1'b0;
    case (state)
      BOOT: begin
        pc_en       = 1'b1;
        pc_jump_en  = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      RUN: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_en         = 1'b1;
          pc_jump_en    = 1'b1;
          pc_jump_addr  = redirect_addr;
          if_id_flush   = 1'b1;
          id_ex_flush   = 1'b1;
          misalign_trap = misaligned;
        end else if (halt_req) begin
          if_id_flush = 1'b1;
        end else if (load_use_stall) begin
          id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          if_id_flush = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
        end
      end
      HALT: begin
        halted      = 1'b1;
        if_id_flush = 1'b1;
        // In-flight jumps still land while halted.
        if (branch_taken) begin
          pc_en         = 1'b1;
          pc_jump_en    = 1'b1;
          pc_jump_addr  = redirect_addr;
          id_ex_flush   = 1'b1;
          misalign_trap = misaligned;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: constant vector table, directed sequences,
// and randomized traffic against a mode/boot-countdown reference model.
module tb_fetch_controller;
  localparam int          BD = 2;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset = 1'b1, branch_taken = 1'b0, load_use_stall = 1'b0;
  logic halt_req = 1'b0, resume = 1'b0, imem_ready = 1'b1;
  logic [31:0] branch_target = '0;
  logic imem_req, pc_en, pc_jump_en, if_id_en, if_id_flush, id_ex_flush, halted, misalign_trap;
  logic [31:0] pc_jump_addr;
  logic [31:0] pc;
  int checks = 0, errors = 0;

  fetch_controller #(.ADDR_WIDTH(32), .RESET_VECTOR(RV), .BOOT_DELAY(BD), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset(reset), .branch_taken(branch_taken), .branch_target(branch_target),
    .load_use_stall(load_use_stall), .halt_req(halt_req), .resume(resume),
    .imem_ready(imem_ready), .imem_req(imem_req), .pc_en(pc_en), .pc_jump_en(pc_jump_en),
    .pc_jump_addr(pc_jump_addr), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .halted(halted), .misalign_trap(misalign_trap));

  always #5 clk = ~clk;

  // Environment PC register driven by the controller outputs.
  always @(posedge clk) if (pc_en) pc <= pc_jump_en ? pc_jump_addr : pc + 32'd4;

  typedef enum {M_BOOT, M_RUN, M_HALT} mode_e;
  mode_e mode = M_BOOT;
  int    boot_left = BD;

  typedef struct packed {
    logic imem_req, pc_en, pc_jump_en;
    logic [31:0] addr;
    logic if_id_en, if_id_flush, id_ex_flush, halted, trap;
  } out_t;

  function automatic out_t model_out();
    out_t o;
    logic [31:0] dest;
    logic mis;
    o = '0;
    o.addr = RV;
    dest = {branch_target[31:2], 2'b00};
    mis  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (branch_target[1:0] != 2'b00) begin dest = TV; mis = 1'b1; end
`endif
    if (mode == M_BOOT) begin
      o.pc_en = 1; o.pc_jump_en = 1; o.if_id_flush = 1; o.id_ex_flush = 1;
    end else begin
      if (mode == M_RUN) o.imem_req = 1;
      else begin o.halted = 1; o.if_id_flush = 1; end
      if (branch_taken) begin
        o.pc_en = 1; o.pc_jump_en = 1; o.addr = dest;
        o.if_id_flush = 1; o.id_ex_flush = 1; o.trap = mis;
      end else if (mode == M_RUN) begin
        if (halt_req)            o.if_id_flush = 1;
        else if (load_use_stall) o.id_ex_flush = 1;
        else if (!imem_ready)    o.if_id_flush = 1;
        else begin o.pc_en = 1; o.if_id_en = 1; end
      end
    end
    return o;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic sample(string nm);
    out_t act, exp;
    @(negedge clk);
    act = {imem_req, pc_en, pc_jump_en, pc_jump_addr, if_id_en, if_id_flush, id_ex_flush,
           halted, misalign_trap};
    exp = model_out();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s outputs actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin mode = M_BOOT; boot_left = BD; end
    else case (mode)
      M_BOOT: begin boot_left--; if (boot_left == 0) mode = M_RUN; end
      M_RUN:  if (!branch_taken && halt_req) mode = M_HALT;
      M_HALT: if (resume) mode = M_RUN;
    endcase
    #1;
  endtask

  task automatic tick(string nm);
    sample(nm);
    advance();
  endtask

  task automatic boot_wait();
    for (int i = 0; i < 20 && mode != M_RUN; i++) tick("boot_wait");
  endtask

  typedef struct {
    logic bt; logic [31:0] tgt; logic st, rdy;
    logic e_pc_en, e_jmp; logic [31:0] e_addr; logic e_ifen, e_iff, e_exf;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{1, 32'hCAFE_BABC, 1, 0, 1, 1, 32'hCAFE_BABC, 0, 1, 1};
    tbl[1] = '{1, 32'h0000_0010, 0, 1, 1, 1, 32'h0000_0010, 0, 1, 1};
    tbl[2] = '{0, 32'h1234_5678, 1, 0, 0, 0, RV,            0, 0, 1};
    tbl[3] = '{0, 32'h1234_5678, 0, 0, 0, 0, RV,            0, 1, 0};
    tbl[4] = '{0, 32'h1234_5678, 0, 1, 1, 0, RV,            1, 0, 0};

    // Reset held 3 cycles, then two boot cycles before the first fetch.
    reset = 1; advance(); tick("rst1"); tick("rst2"); reset = 0;
    sample("boot1"); check("boot1_imem_req", 32'(imem_req), 0);
    check("boot1_jump_addr", pc_jump_addr, RV); check("boot1_halted", 32'(halted), 0);
    advance();
    sample("boot2"); check("boot2_flush", {if_id_flush, id_ex_flush}, 2'b11); advance();
    sample("run0"); check("first_imem_req", 32'(imem_req), 1); check("pc0", pc, 32'h0); advance();
    check("pc4", pc, 32'h4); tick("run1");
    check("pc8", pc, 32'h8);

    // Redirect with a coincident stall: the stall is discarded.
    branch_taken = 1; branch_target = 32'hCAFE_BABC; load_use_stall = 1;
    sample("redir"); check("redir_jump_en", 32'(pc_jump_en), 1); advance();
    branch_taken = 0; load_use_stall = 0;
    check("pc_target", pc, 32'hCAFE_BABC); tick("post_redir");
    check("pc_target4", pc, 32'hCAFE_BAC0);

    // Stall 2 cycles, imem wait 3 cycles, then streaming.
    load_use_stall = 1; tick("stall1"); tick("stall2"); load_use_stall = 0;
    check("pc_stall_hold", pc, 32'hCAFE_BAC0);
    imem_ready = 0; tick("wait1"); tick("wait2"); tick("wait3"); imem_ready = 1;
    check("pc_wait_hold", pc, 32'hCAFE_BAC0);
    tick("stream1"); tick("stream2");
    check("pc_stream", pc, 32'hCAFE_BAC8);

    // Constant vector table, applied in RUN.
    for (int i = 0; i < 5; i++) begin
      branch_taken = tbl[i].bt; branch_target = tbl[i].tgt;
      load_use_stall = tbl[i].st; imem_ready = tbl[i].rdy;
      sample($sformatf("tbl%0d_model", i));
      check($sformatf("tbl%0d_ctl", i),
            {pc_en, pc_jump_en, if_id_en, if_id_flush, id_ex_flush},
            {tbl[i].e_pc_en, tbl[i].e_jmp, tbl[i].e_ifen, tbl[i].e_iff, tbl[i].e_exf});
      check($sformatf("tbl%0d_addr", i), pc_jump_addr, tbl[i].e_addr);
      advance();
    end
    branch_taken = 0; load_use_stall = 0; imem_ready = 1;

    // Halt at 0x20, resume, halt again and redirect while halted.
    branch_taken = 1; branch_target = 32'h20; tick("to20"); branch_taken = 0;
    halt_req = 1; tick("halt_req"); halt_req = 0;
    sample("halted1"); check("halted_set", {halted, imem_req}, 2'b10); advance();
    tick("halted2"); check("pc_halt_hold", pc, 32'h20);
    resume = 1; tick("resume"); resume = 0;
    sample("resumed"); check("resume_req", {halted, imem_req}, 2'b01);
    check("resume_pc", pc, 32'h20); advance();
    halt_req = 1; tick("halt_req2"); halt_req = 0;
    branch_taken = 1; branch_target = 32'h40; tick("halt_redir"); branch_taken = 0;
    check("pc_halt_redir", pc, 32'h40);
    sample("halted3"); check("halted_after_redir", 32'(halted), 1);

    // Reset while halted.
    reset = 1; advance(); reset = 0;
    sample("rst_halt"); check("rst_halt_halted", 32'(halted), 0); advance();
    check("rst_halt_pc", pc, RV);
    boot_wait();

    // Reset in the same cycle as a redirect.
    branch_taken = 1; branch_target = 32'h80; reset = 1; tick("rst_redir");
    branch_taken = 0; reset = 0;
    sample("rst_redir_boot"); check("rst_redir_req", 32'(imem_req), 0); advance();
    check("rst_redir_pc", pc, RV);
    boot_wait();

    // Misaligned redirect target.
    branch_taken = 1; branch_target = 32'hCAFE_BABE;
    sample("misalign");
`ifdef FETCH_MISALIGN_TRAP_EN
    check("misalign_trap", 32'(misalign_trap), 1);
`else
    check("misalign_trap", 32'(misalign_trap), 0);
`endif
    advance(); branch_taken = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("misalign_pc", pc, TV);
`else
    check("misalign_pc", pc, 32'hCAFE_BABC);
`endif
    sample("misalign_after"); check("misalign_pulse_end", 32'(misalign_trap), 0); advance();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(99) < 2);
      branch_taken   = ($urandom_range(99) < 15);
      branch_target  = $urandom;
      load_use_stall = ($urandom_range(99) < 20);
      halt_req       = ($urandom_range(99) < 8);
      resume         = ($urandom_range(99) < 25);
      imem_ready     = ($urandom_range(99) < 75);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
